irq_encoder_32to5: RTL and testbench

Sequential 32-to-5 interrupt request encoder for the MIPS core: the encoding counterpart of the 5-to-32 register-select decoder. Latches rising edges on 32 request lines into a pending register, applies a software mask, and presents one 5-bit request ID at a time to the exception unit over a valid/ack handshake. The CPU loads the presented ID into the Cause path. Acknowledging the ID clears that pending bit.

---
 rtl/irq_encoder_32to5_pkg.sv | 16 +
 rtl/irq_encoder_32to5_if.sv | 13 +
 rtl/prio_enc_32to5.sv | 21 ++
 rtl/irq_encoder_32to5.sv | 118 +++++++++++
 tb/tb_irq_encoder_32to5.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_encoder_32to5_pkg.sv
// Shared definitions for the 32-to-5 interrupt request encoder.
package irq_enc_pkg;

  localparam int NUM_IRQ = 32;
  localparam int ID_W    = 5;

  typedef logic [ID_W-1:0]    irq_id_t;
  typedef logic [NUM_IRQ-1:0] irq_vec_t;

  // Presentation FSM: IDLE looks for a candidate, PRESENT holds one ID until acked.
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_e;

endpackage

// File: rtl/irq_encoder_32to5_if.sv
// Valid/ack handshake between the interrupt encoder and the exception unit.
// master: encoder side (presents ID); slave: CPU side (acknowledges).
interface irq_encoder_32to5_if;
  import irq_enc_pkg::*;

  logic    irq_valid;
  irq_id_t irq_id;
  logic    irq_ack;

  modport master (output irq_valid, output irq_id, input irq_ack);
  modport slave  (input irq_valid, input irq_id, output irq_ack);

endinterface

// File: rtl/prio_enc_32to5.sv
// Purely combinational 32-to-5 priority encoder: reports the lowest set bit.
module prio_enc_32to5
  import irq_enc_pkg::*;
(
  input  irq_vec_t req,
  output logic     any,
  output irq_id_t  idx
);

  assign any = |req;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) idx = i[ID_W-1:0];
    end
  end

endmodule

// File: rtl/irq_encoder_32to5.sv
// Sequential 32-to-5 interrupt request encoder.
// Rising edges on irq_in pend requests; pending & mask are candidates; one ID
// at a time is presented over the valid/ack handshake.
// Optional macro IRQ_ENC_RR_EN: rotating priority with a last-granted pointer.
// Without it, fixed priority (lowest index wins).
module irq_encoder_32to5
  import irq_enc_pkg::*;
#(
  parameter logic [31:0] MASK_RESET = 32'hFFFF_FFFF
) (
  input  logic                clk,
  input  logic                rst,
  input  irq_vec_t            irq_in,
  input  logic                mask_we,
  input  irq_vec_t            mask_wdata,
  irq_encoder_32to5_if.master bus,
  output irq_vec_t            pending,
  output irq_vec_t            mask
);

  state_e   state_q, state_d;
  irq_id_t  id_q, id_d;
  irq_vec_t irq_q;
  irq_vec_t rise;
  irq_vec_t clr;
  irq_vec_t cand;
  logic     ack_acc;
  logic     enc_any;
  irq_id_t  enc_idx;
  irq_id_t  sel_idx;
  irq_vec_t enc_req;

  assign rise    = irq_in & ~irq_q;
  assign ack_acc = (state_q == PRESENT) && bus.irq_ack;
  // The registered mask is used, so a write in the same cycle only affects the next check.
  assign cand    = pending & mask;

  // One-hot clear of the presented bit when its ack is accepted.
  always_comb begin
    clr = '0;
    if (ack_acc) clr[id_q] = 1'b1;
  end

`ifdef IRQ_ENC_RR_EN
  irq_id_t               last_q;
  irq_id_t               rot_amt;
  logic [2*NUM_IRQ-1:0]  cand_dbl;

  // Rotate right so index last+1 lands at bit 0, then undo the offset (mod 32).
  assign rot_amt  = last_q + 5'd1;
  assign cand_dbl = {cand, cand} >> rot_amt;
  assign enc_req  = cand_dbl[NUM_IRQ-1:0];
  assign sel_idx  = enc_idx + rot_amt;

  // Last-granted pointer follows every accepted ack.
  always_ff @(posedge clk) begin
    if (rst)          last_q <= 5'd31;
    else if (ack_acc) last_q <= id_q;
  end
`else
  assign enc_req = cand;
  assign sel_idx = enc_idx;
`endif

  prio_enc_32to5 u_prio (
    .req (enc_req),
    .any (enc_any),
    .idx (enc_idx)
  );

  // Input history, pending set/clear (a new edge beats a same-cycle clear) and mask register.
  always_ff @(posedge clk) begin
    // NOTE: the edge-detect history is reset to 0 so lines already high at reset release pend once.
    if (rst) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= MASK_RESET;
    end else begin
      // NOTE: non-blocking assignments keep every register reading last cycle's values.
      irq_q   <= irq_in;
      pending <= rise | (pending & ~clr);
      if (mask_we) mask <= mask_wdata;
    end
  end

  // FSM state and presented-ID registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
    end
  end

  // Next-state logic: latch a candidate in IDLE, hold it in PRESENT until acked.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (enc_any) begin
          state_d = PRESENT;
          id_d    = sel_idx;
        end
      end
      PRESENT: begin
        if (bus.irq_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.irq_valid = (state_q == PRESENT);
  assign bus.irq_id    = id_q;

endmodule

// File: tb/tb_irq_encoder_32to5.sv
// Directed self-checking bench for irq_encoder_32to5.
module tb_irq_encoder_32to5;
  import irq_enc_pkg::*;

  logic     clk;
  logic     rst;
  irq_vec_t irq_in;
  logic     mask_we;
  irq_vec_t mask_wdata;
  irq_vec_t pending;
  irq_vec_t mask;

  int passed = 0;
  int total  = 0;

  irq_encoder_32to5_if bus ();

  irq_encoder_32to5 #(.MASK_RESET(32'hFFFF_FFFF)) dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .bus        (bus.master),
    .pending    (pending),
    .mask       (mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++;
      if ({bus.irq_valid, bus.irq_id, pending, mask} !== {1'b0, 5'd0, 32'h0, 32'hFFFF_FFFF})
        $display("FAIL reset cyc%0d: valid=%b id=%0d pending=%h mask=%h, want 0/0/0/ffffffff",
                 c, bus.irq_valid, bus.irq_id, pending, mask);
      else passed++;
    end
  endtask

  task automatic test_request();
    irq_in = 32'h1 << 5;
    tick();
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h0000_0020})
      $display("FAIL req_pend5: valid=%b pending=%h, want 0/00000020", bus.irq_valid, pending);
    else passed++;
    irq_in = 32'h1 << 17;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id, pending} !== {1'b1, 5'd5, 32'h0002_0020})
      $display("FAIL req_present5: valid=%b id=%0d pending=%h, want 1/5/00020020",
               bus.irq_valid, bus.irq_id, pending);
    else passed++;
    irq_in = '0;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h0002_0000})
      $display("FAIL req_ack5: valid=%b pending=%h, want 0/00020000", bus.irq_valid, pending);
    else passed++;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, 5'd17})
      $display("FAIL req_present17: valid=%b id=%0d, want 1/17", bus.irq_valid, bus.irq_id);
    else passed++;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h0})
      $display("FAIL req_ack17: valid=%b pending=%h, want 0/00000000", bus.irq_valid, pending);
    else passed++;
  endtask

  task automatic test_mask();
    mask_we = 1'b1;
    mask_wdata = 32'hFFFF_FFFE;
    tick();
    mask_we = 1'b0;
    total++;
    if (mask !== 32'hFFFF_FFFE)
      $display("FAIL mask_write: mask=%h, want fffffffe", mask);
    else passed++;
    irq_in = 32'h1;
    tick();
    irq_in = '0;
    tick();
    tick();
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h1})
      $display("FAIL mask_blocked: valid=%b pending=%h, want 0/00000001", bus.irq_valid, pending);
    else passed++;
    mask_we = 1'b1;
    mask_wdata = 32'hFFFF_FFFF;
    tick();
    mask_we = 1'b0;
    total++;
    if (bus.irq_valid !== 1'b0)
      $display("FAIL mask_old_used: valid=%b, want 0", bus.irq_valid);
    else passed++;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, 5'd0})
      $display("FAIL mask_unmasked: valid=%b id=%0d, want 1/0", bus.irq_valid, bus.irq_id);
    else passed++;
    mask_we = 1'b1;
    mask_wdata = 32'hFFFF_FFFE;
    tick();
    mask_we = 1'b0;
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, 5'd0})
      $display("FAIL mask_no_retract: valid=%b id=%0d, want 1/0", bus.irq_valid, bus.irq_id);
    else passed++;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h0})
      $display("FAIL mask_ack: valid=%b pending=%h, want 0/00000000", bus.irq_valid, pending);
    else passed++;
    mask_we = 1'b1;
    mask_wdata = 32'hFFFF_FFFF;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic test_ack_idle();
    irq_in = 32'h1 << 12;
    bus.irq_ack = 1'b1;
    tick();
    irq_in = '0;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id, pending} !== {1'b1, 5'd12, 32'h0000_1000})
      $display("FAIL ack_idle_ignored: valid=%b id=%0d pending=%h, want 1/12/00001000",
               bus.irq_valid, bus.irq_id, pending);
    else passed++;
    tick();
    bus.irq_ack = 1'b0;
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h0})
      $display("FAIL ack_idle_accept: valid=%b pending=%h, want 0/00000000", bus.irq_valid, pending);
    else passed++;
  endtask

  task automatic test_edge_vs_ack();
    irq_in = 32'h8;
    tick();
    tick();
    irq_in = '0;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, 5'd3})
      $display("FAIL eva_present3: valid=%b id=%0d, want 1/3", bus.irq_valid, bus.irq_id);
    else passed++;
    irq_in = 32'h8;
    bus.irq_ack = 1'b1;
    tick();
    irq_in = '0;
    bus.irq_ack = 1'b0;
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h8})
      $display("FAIL eva_edge_wins: valid=%b pending=%h, want 0/00000008", bus.irq_valid, pending);
    else passed++;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, 5'd3})
      $display("FAIL eva_represent3: valid=%b id=%0d, want 1/3", bus.irq_valid, bus.irq_id);
    else passed++;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h0})
      $display("FAIL eva_drain: valid=%b pending=%h, want 0/00000000", bus.irq_valid, pending);
    else passed++;
  endtask

  task automatic test_reset_in_present();
    irq_in = 32'h1 << 9;
    tick();
    irq_in = '0;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, 5'd9})
      $display("FAIL rstp_present9: valid=%b id=%0d, want 1/9", bus.irq_valid, bus.irq_id);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({bus.irq_valid, bus.irq_id, pending} !== {1'b0, 5'd0, 32'h0})
      $display("FAIL rstp_cleared: valid=%b id=%0d pending=%h, want 0/0/00000000",
               bus.irq_valid, bus.irq_id, pending);
    else passed++;
    tick();
    tick();
    tick();
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h0})
      $display("FAIL rstp_no_repeat: valid=%b pending=%h, want 0/00000000", bus.irq_valid, pending);
    else passed++;
  endtask

  task automatic test_priority();
    irq_id_t exp_first;
    irq_id_t exp_second;
`ifdef IRQ_ENC_RR_EN
    exp_first  = 5'd7;
    exp_second = 5'd2;
`else
    exp_first  = 5'd2;
    exp_second = 5'd7;
`endif
    irq_in = 32'h84;
    tick();
    irq_in = '0;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id, pending} !== {1'b1, 5'd2, 32'h84})
      $display("FAIL prio_first2: valid=%b id=%0d pending=%h, want 1/2/00000084",
               bus.irq_valid, bus.irq_id, pending);
    else passed++;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, 5'd7})
      $display("FAIL prio_then7: valid=%b id=%0d, want 1/7", bus.irq_valid, bus.irq_id);
    else passed++;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    irq_in = 32'h84;
    tick();
    irq_in = '0;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, 5'd2})
      $display("FAIL prio_again2: valid=%b id=%0d, want 1/2", bus.irq_valid, bus.irq_id);
    else passed++;
    // Ack 2 while re-pending 2; 7 is still pending, so 2 and 7 compete next.
    irq_in = 32'h4;
    bus.irq_ack = 1'b1;
    tick();
    irq_in = '0;
    bus.irq_ack = 1'b0;
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h84})
      $display("FAIL prio_compete_pend: valid=%b pending=%h, want 0/00000084", bus.irq_valid, pending);
    else passed++;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, exp_first})
      $display("FAIL prio_compete_first: valid=%b id=%0d, want 1/%0d",
               bus.irq_valid, bus.irq_id, exp_first);
    else passed++;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    tick();
    total++;
    if ({bus.irq_valid, bus.irq_id} !== {1'b1, exp_second})
      $display("FAIL prio_compete_second: valid=%b id=%0d, want 1/%0d",
               bus.irq_valid, bus.irq_id, exp_second);
    else passed++;
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    total++;
    if ({bus.irq_valid, pending} !== {1'b0, 32'h0})
      $display("FAIL prio_drain: valid=%b pending=%h, want 0/00000000", bus.irq_valid, pending);
    else passed++;
  endtask

  initial begin
    rst         = 1'b1;
    irq_in      = '0;
    mask_we     = 1'b0;
    mask_wdata  = '0;
    bus.irq_ack = 1'b0;
    #2;
    test_reset();
    test_request();
    test_mask();
    test_ack_idle();
    test_edge_vs_ack();
    test_reset_in_present();
    test_priority();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
